// File: rtl/uart_tx_arbiter_pkg.sv
// Shared types and helpers for the UART transmit arbiter slice.
package uart_tx_arbiter_pkg;

  localparam int DEFAULT_DATA_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_LAUNCH    = 3'd1,
    ST_WAIT_BUSY = 3'd2,
    ST_WAIT_DONE = 3'd3,
    ST_ACK       = 3'd4
  } arb_state_e;

  // Width needed to index 'value' items; never narrower than one bit.
  function automatic int clog2(input int value);
    int result;
    result = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < value) begin
        result = i + 1;
      end
    end
    return result;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or above the pointer, wrapping.
module uart_tx_arbiter_rr_pick
  import uart_tx_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   ptr_i,
  output logic               valid_o,
  output logic [IDX_W-1:0]   winner_o
);

  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_REQ - 1);

  // Walk the requesters starting at the pointer; wrap by compare so odd counts work.
  always_comb begin
    logic [IDX_W-1:0] idx;
    valid_o  = 1'b0;
    winner_o = '0;
    idx      = ptr_i;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!valid_o && req_i[idx]) begin
        valid_o  = 1'b1;
        winner_o = idx;
      end
      idx = (idx == IDX_LAST) ? '0 : idx + IDX_W'(1);
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter among NUM_REQ byte sources with round-robin arbitration.
// A grant latches the byte, pulses tx_start, waits for the frame (or a start timeout),
// then acks the source and moves the rotation pointer past it.
module uart_tx_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter int NUM_REQ       = 4,
  parameter int DATA_W        = DEFAULT_DATA_W,
  parameter int START_TIMEOUT = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_REQ-1:0]          req,
  input  logic [NUM_REQ*DATA_W-1:0]   req_data,
  output logic [NUM_REQ-1:0]          ack,
  output logic                        tx_err,
  output logic                        tx_start,
  output logic [DATA_W-1:0]           tx_data,
  input  logic                        tx_busy,
  output logic [clog2(NUM_REQ)-1:0]   grant_id,
  output logic                        arb_busy
);

  localparam int IDX_W = clog2(NUM_REQ);
  localparam int CNT_W = clog2(START_TIMEOUT);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_REQ - 1);
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(START_TIMEOUT - 2);

  arb_state_e          state_q, state_d;
  logic [IDX_W-1:0]    ptr_q, ptr_d;
  logic [IDX_W-1:0]    grantId_q, grantId_d;
  logic [CNT_W-1:0]    startCnt_q, startCnt_d;
  logic                drop_q, drop_d;
  logic [DATA_W-1:0]   txData_q, txData_d;
  logic [NUM_REQ-1:0]  ack_q, ack_d;
  logic                txErr_q, txErr_d;
  logic                txStart_q, txStart_d;
  logic                arbBusy_q, arbBusy_d;

  logic                pickValid;
  logic [IDX_W-1:0]    pickIdx;

  uart_tx_arbiter_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_pick (
    .req_i    (req),
    .ptr_i    (ptr_q),
    .valid_o  (pickValid),
    .winner_o (pickIdx)
  );

  // Next-state logic; outputs are derived from the state being entered so they register cleanly.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    grantId_d  = grantId_q;
    startCnt_d = startCnt_q;
    drop_d     = drop_q;
    txData_d   = txData_q;

    unique case (state_q)
      ST_IDLE: begin
        if (pickValid && !tx_busy) begin
          grantId_d = pickIdx;
          for (int i = 0; i < NUM_REQ; i++) begin
            if (pickIdx == IDX_W'(i)) begin
              txData_d = req_data[i*DATA_W +: DATA_W];
            end
          end
          state_d = ST_LAUNCH;
        end
      end
      ST_LAUNCH: begin
        startCnt_d = '0;
        state_d    = ST_WAIT_BUSY;
      end
      ST_WAIT_BUSY: begin
        if (tx_busy) begin
          state_d = ST_WAIT_DONE;
        end else begin
          startCnt_d = startCnt_q + CNT_W'(1);
          if (startCnt_q == CNT_LIMIT) begin
            drop_d  = 1'b1;
            state_d = ST_ACK;
          end
        end
      end
      ST_WAIT_DONE: begin
        if (!tx_busy) begin
          state_d = ST_ACK;
        end
      end
      ST_ACK: begin
        ptr_d   = (grantId_q == IDX_LAST) ? '0 : grantId_q + IDX_W'(1);
        drop_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    txStart_d = (state_d == ST_LAUNCH);
    arbBusy_d = (state_d != ST_IDLE);
    txErr_d   = (state_d == ST_ACK) && drop_d;
    for (int i = 0; i < NUM_REQ; i++) begin
      ack_d[i] = (state_d == ST_ACK) && (grantId_d == IDX_W'(i));
    end
  end

  // FSM state, rotation pointer, timeout counter and drop flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      ptr_q      <= '0;
      grantId_q  <= '0;
      startCnt_q <= '0;
      drop_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      grantId_q  <= grantId_d;
      startCnt_q <= startCnt_d;
      drop_q     <= drop_d;
    end
  end

  // Registered outputs and the latched byte.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      txData_q  <= '0;
      ack_q     <= '0;
      txErr_q   <= 1'b0;
      txStart_q <= 1'b0;
      arbBusy_q <= 1'b0;
    end else begin
      txData_q  <= txData_d;
      ack_q     <= ack_d;
      txErr_q   <= txErr_d;
      txStart_q <= txStart_d;
      arbBusy_q <= arbBusy_d;
    end
  end

  assign ack      = ack_q;
  assign tx_err   = txErr_q;
  assign tx_start = txStart_q;
  assign tx_data  = txData_q;
  assign grant_id = grantId_q;
  assign arb_busy = arbBusy_q;

endmodule
